// File: rtl/ahb_burst_arbiter_pkg.sv
// Shared types, AHB encodings and beat-geometry helpers for the IFU/LSU AHB burst arbiter.
package ahb_burst_arbiter_pkg;

  typedef struct packed {
    int   AHBW;
    logic BURST_EN;
    int   ICACHE_LINELENINBITS;
    int   DCACHE_LINELENINBITS;
  } cvw_t;

  localparam cvw_t CVW_DEFAULT = '{AHBW: 32, BURST_EN: 1'b1,
                                   ICACHE_LINELENINBITS: 128, DCACHE_LINELENINBITS: 128};

  typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA} arbstate_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  // A burst always covers the larger of the two cache lines.
  function automatic int calc_beats(cvw_t p);
    int line;
    line = (p.ICACHE_LINELENINBITS > p.DCACHE_LINELENINBITS) ?
           p.ICACHE_LINELENINBITS : p.DCACHE_LINELENINBITS;
    return line / p.AHBW;
  endfunction

  function automatic int calc_logbeats(int beats);
    return (beats <= 2) ? 1 : $clog2(beats);
  endfunction

  function automatic logic [2:0] hburst_code(int beats);
    case (beats)
      4:       return HBURST_INCR4;
      8:       return HBURST_INCR8;
      16:      return HBURST_INCR16;
      default: return HBURST_INCR;
    endcase
  endfunction

endpackage

// File: rtl/ahb_burst_arbiter_if.sv
// Requester/bus-facing signal bundle of the arbiter; master = arbiter side, slave = environment side.
interface ahb_burst_arbiter_if #(parameter int LOGBEATS = 2);
  // Handshake: a requester raises XReq (with XBurst valid at the same time) and holds it until it
  // sees its one-cycle XDone pulse; the transfer advances only in cycles where HREADY is high.
  logic                IFUReq;
  logic                IFUBurst;
  logic                LSUReq;
  logic                LSUBurst;
  logic                HREADY;
  logic [1:0]          Grant;
  logic [1:0]          HTRANS;
  logic [2:0]          HBURST;
  logic [LOGBEATS-1:0] BeatIdx;
  logic                LastAddr;
  logic                IFUDone;
  logic                LSUDone;

  modport master (
    input  IFUReq, IFUBurst, LSUReq, LSUBurst, HREADY,
    output Grant, HTRANS, HBURST, BeatIdx, LastAddr, IFUDone, LSUDone
  );

  modport slave (
    output IFUReq, IFUBurst, LSUReq, LSUBurst, HREADY,
    input  Grant, HTRANS, HBURST, BeatIdx, LastAddr, IFUDone, LSUDone
  );
endinterface

// File: rtl/ahb_burst_arbiter_beatcounter.sv
// Address-phase beat counter: restarts at 0 when a transaction is granted, advances on HREADY.
module arb_beatcounter #(
  parameter int                  LOGBEATS  = 2,
  parameter logic [LOGBEATS-1:0] LAST_BEAT = '1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                load_burst,
  input  logic                advance,
  output logic [LOGBEATS-1:0] beat_idx,
  output logic                at_last
);
  logic [LOGBEATS-1:0] cnt_q;
  logic [LOGBEATS-1:0] last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      last_q <= '0;
    end else if (load) begin
      cnt_q  <= '0;
      last_q <= load_burst ? LAST_BEAT : '0;
    end else if (advance && !at_last) begin
      cnt_q  <= cnt_q + LOGBEATS'(1);
    end
  end

  assign beat_idx = cnt_q;
  assign at_last  = (cnt_q == last_q);
endmodule

// File: rtl/ahb_burst_arbiter.sv
// Arbitrates the AHB manager port between IFU and LSU and sequences the winner's single/burst transfer.
module ahb_burst_arbiter
  import ahb_burst_arbiter_pkg::*;
#(
  parameter cvw_t P            = CVW_DEFAULT,
  parameter int   STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  ahb_burst_arbiter_if.master bus,
  output arbstate_t           dbg_state
);
  localparam int                  BEATS     = calc_beats(P);
  localparam int                  LOGBEATS  = calc_logbeats(BEATS);
  localparam logic [LOGBEATS-1:0] LAST_BEAT = LOGBEATS'(BEATS - 1);
  localparam logic [2:0]          BURST_CODE = hburst_code(BEATS);
  localparam int                  SW        = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]       STARVE_MAX = SW'(STARVE_LIMIT);

  arbstate_t     state_q, state_d;
  logic          owner_ifu_q, owner_ifu_d;
  logic          burst_q, burst_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          ifu_done_q, ifu_done_d;
  logic          lsu_done_q, lsu_done_d;

  logic                load;
  logic                ifu_wins;
  logic [LOGBEATS-1:0] beat_idx;
  logic                at_last;

  arb_beatcounter #(.LOGBEATS(LOGBEATS), .LAST_BEAT(LAST_BEAT)) u_beatcounter (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_burst (burst_d),
    .advance    ((state_q == ARB_ADDR) && bus.HREADY),
    .beat_idx   (beat_idx),
    .at_last    (at_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      owner_ifu_q <= 1'b0;
      burst_q     <= 1'b0;
      starve_q    <= '0;
      ifu_done_q  <= 1'b0;
      lsu_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_ifu_q <= owner_ifu_d;
      burst_q     <= burst_d;
      starve_q    <= starve_d;
      ifu_done_q  <= ifu_done_d;
      lsu_done_q  <= lsu_done_d;
    end
  end

  // LSU wins contention until the IFU has lost STARVE_LIMIT times in a row.
  assign ifu_wins = bus.IFUReq && (!bus.LSUReq || (starve_q == STARVE_MAX));

  always_comb begin
    state_d     = state_q;
    owner_ifu_d = owner_ifu_q;
    burst_d     = burst_q;
    starve_d    = starve_q;
    ifu_done_d  = 1'b0;
    lsu_done_d  = 1'b0;
    load        = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (bus.IFUReq || bus.LSUReq) begin
          state_d     = ARB_ADDR;
          load        = 1'b1;
          owner_ifu_d = ifu_wins;
          burst_d     = ifu_wins ? bus.IFUBurst : bus.LSUBurst;
          if (ifu_wins)
            starve_d = '0;
          else if (bus.IFUReq && (starve_q != STARVE_MAX))
            starve_d = starve_q + SW'(1);
        end
      end
      ARB_ADDR: begin
        if (bus.HREADY && at_last) state_d = ARB_DATA;
      end
      ARB_DATA: begin
        if (bus.HREADY) begin
          state_d    = ARB_IDLE;
          ifu_done_d = owner_ifu_q;
          lsu_done_d = !owner_ifu_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.Grant    = 2'b00;
    bus.HTRANS   = HTRANS_IDLE;
    bus.HBURST   = HBURST_SINGLE;
    bus.LastAddr = 1'b0;
    if (state_q != ARB_IDLE)
      bus.Grant = owner_ifu_q ? 2'b01 : 2'b10;
    if (state_q == ARB_ADDR) begin
      bus.HTRANS   = ((beat_idx == '0) || !P.BURST_EN) ? HTRANS_NONSEQ : HTRANS_SEQ;
      bus.HBURST   = (P.BURST_EN && burst_q) ? BURST_CODE : HBURST_SINGLE;
      bus.LastAddr = at_last;
    end
  end

  assign bus.BeatIdx = beat_idx;
  assign bus.IFUDone = ifu_done_q;
  assign bus.LSUDone = lsu_done_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_ahb_burst_arbiter.sv
// Directed bench for the IFU/LSU AHB arbiter: a 4-beat bursting instance and an 8-beat non-bursting one.
module tb_ahb_burst_arbiter;
  import ahb_burst_arbiter_pkg::*;

  localparam cvw_t P_A = '{AHBW: 32, BURST_EN: 1'b1,
                           ICACHE_LINELENINBITS: 128, DCACHE_LINELENINBITS: 128};
  localparam cvw_t P_B = '{AHBW: 32, BURST_EN: 1'b0,
                           ICACHE_LINELENINBITS: 256, DCACHE_LINELENINBITS: 128};

  logic      clk;
  logic      reset;
  arbstate_t dbg_a, dbg_b;
  int        checks;
  int        errors;

  ahb_burst_arbiter_if #(.LOGBEATS(2)) bus_a ();
  ahb_burst_arbiter_if #(.LOGBEATS(3)) bus_b ();

  ahb_burst_arbiter #(.P(P_A), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .dbg_state(dbg_a)
  );
  ahb_burst_arbiter #(.P(P_B), .STARVE_LIMIT(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .dbg_state(dbg_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [1:0] g, input logic [1:0] ht,
                         input logic [1:0] idx, input logic last, input logic idone,
                         input logic ldone);
    check_eq({tag, "_grant"},  32'(bus_a.Grant),    32'(g));
    check_eq({tag, "_htrans"}, 32'(bus_a.HTRANS),   32'(ht));
    check_eq({tag, "_beat"},   32'(bus_a.BeatIdx),  32'(idx));
    check_eq({tag, "_last"},   32'(bus_a.LastAddr), 32'(last));
    check_eq({tag, "_idone"},  32'(bus_a.IFUDone),  32'(idone));
    check_eq({tag, "_ldone"},  32'(bus_a.LSUDone),  32'(ldone));
  endtask

  // Outputs are registered, so checking 1 time unit after the edge is stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus_a.IFUReq = 0; bus_a.IFUBurst = 0; bus_a.LSUReq = 0; bus_a.LSUBurst = 0; bus_a.HREADY = 1;
    bus_b.IFUReq = 0; bus_b.IFUBurst = 0; bus_b.LSUReq = 0; bus_b.LSUBurst = 0; bus_b.HREADY = 1;
    tick();
    tick();

    // reset state
    check_a("rst", 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_hburst", 32'(bus_a.HBURST), 32'd0);
    check_eq("rst_state", 32'(dbg_a), 32'(ARB_IDLE));
    check_eq("rst_b_grant", 32'(bus_b.Grant), 32'd0);
    check_eq("rst_b_beat", 32'(bus_b.BeatIdx), 32'd0);

    // 1: IFU 4-beat burst with BURST_EN
    reset = 1'b0;
    bus_a.IFUReq = 1'b1; bus_a.IFUBurst = 1'b1;
    check_a("t1_c0", 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_a($sformatf("t1_b%0d", k), 2'b01, (k == 0) ? 2'b10 : 2'b11, 2'(k), k == 3, 1'b0, 1'b0);
      check_eq($sformatf("t1_hburst%0d", k), 32'(bus_a.HBURST), 32'h3);
      bus_a.IFUBurst = 1'b0;
    end
    tick();
    check_a("t1_data", 2'b01, 2'b00, 2'd3, 1'b0, 1'b0, 1'b0);
    tick();
    check_a("t1_done", 2'b00, 2'b00, 2'd3, 1'b0, 1'b1, 1'b0);
    bus_a.IFUReq = 1'b0;
    tick();
    check_a("t1_idle", 2'b00, 2'b00, 2'd3, 1'b0, 1'b0, 1'b0);

    // 2: simultaneous single-beat requests, LSU first
    bus_a.IFUReq = 1'b1; bus_a.LSUReq = 1'b1;
    tick();
    check_a("t2_lsu_addr", 2'b10, 2'b10, 2'd0, 1'b1, 1'b0, 1'b0);
    check_eq("t2_hburst", 32'(bus_a.HBURST), 32'h0);
    tick();
    check_a("t2_lsu_data", 2'b10, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check_a("t2_lsu_done", 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 1'b1);
    bus_a.LSUReq = 1'b0;
    tick();
    check_a("t2_ifu_addr", 2'b01, 2'b10, 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check_a("t2_ifu_data", 2'b01, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check_a("t2_ifu_done", 2'b00, 2'b00, 2'd0, 1'b0, 1'b1, 1'b0);
    bus_a.IFUReq = 1'b0;
    tick();
    check_a("t2_idle", 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);

    // 3: both held -> L L L L I (counter cleared) L L L L I
    bus_a.IFUReq = 1'b1; bus_a.LSUReq = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      check_eq($sformatf("t3_grant%0d", t), 32'(bus_a.Grant), (t % 5 == 4) ? 32'h1 : 32'h2);
      check_eq($sformatf("t3_htrans%0d", t), 32'(bus_a.HTRANS), 32'h2);
      tick();
      tick();
      check_eq($sformatf("t3_gfree%0d", t), 32'(bus_a.Grant), 32'h0);
      check_eq($sformatf("t3_idone%0d", t), 32'(bus_a.IFUDone), (t % 5 == 4) ? 32'h1 : 32'h0);
      check_eq($sformatf("t3_ldone%0d", t), 32'(bus_a.LSUDone), (t % 5 == 4) ? 32'h0 : 32'h1);
      if (t == 9) begin
        bus_a.IFUReq = 1'b0; bus_a.LSUReq = 1'b0;
      end
    end
    tick();
    check_a("t3_idle", 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);

    // 4: BURST_EN=0, 8-beat LSU burst on instance B
    bus_b.LSUReq = 1'b1; bus_b.LSUBurst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq($sformatf("t4_grant%0d", k),  32'(bus_b.Grant),    32'h2);
      check_eq($sformatf("t4_htrans%0d", k), 32'(bus_b.HTRANS),   32'h2);
      check_eq($sformatf("t4_hburst%0d", k), 32'(bus_b.HBURST),   32'h0);
      check_eq($sformatf("t4_beat%0d", k),   32'(bus_b.BeatIdx),  32'(k));
      check_eq($sformatf("t4_last%0d", k),   32'(bus_b.LastAddr), (k == 7) ? 32'h1 : 32'h0);
    end
    tick();
    check_eq("t4_data_grant", 32'(bus_b.Grant), 32'h2);
    check_eq("t4_data_htrans", 32'(bus_b.HTRANS), 32'h0);
    tick();
    check_eq("t4_done", 32'(bus_b.LSUDone), 32'h1);
    check_eq("t4_done_grant", 32'(bus_b.Grant), 32'h0);
    bus_b.LSUReq = 1'b0;
    tick();
    check_eq("t4_done_pulse", 32'(bus_b.LSUDone), 32'h0);

    // 5: HREADY low for 3 cycles while beat 2 is in address phase
    bus_a.IFUReq = 1'b1; bus_a.IFUBurst = 1'b1;
    tick();
    check_a("t5_b0", 2'b01, 2'b10, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check_a("t5_b1", 2'b01, 2'b11, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    check_a("t5_b2", 2'b01, 2'b11, 2'd2, 1'b0, 1'b0, 1'b0);
    bus_a.HREADY = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check_a($sformatf("t5_stall%0d", s), 2'b01, 2'b11, 2'd2, 1'b0, 1'b0, 1'b0);
      if (s == 2) bus_a.HREADY = 1'b1;
    end
    tick();
    check_a("t5_b3", 2'b01, 2'b11, 2'd3, 1'b1, 1'b0, 1'b0);
    tick();
    check_a("t5_data", 2'b01, 2'b00, 2'd3, 1'b0, 1'b0, 1'b0);
    tick();
    check_a("t5_done", 2'b00, 2'b00, 2'd3, 1'b0, 1'b1, 1'b0);
    bus_a.IFUReq = 1'b0;

    // 6: reset during beat 1 of an LSU burst
    tick();
    bus_a.LSUReq = 1'b1; bus_a.LSUBurst = 1'b1;
    tick();
    check_a("t6_b0", 2'b10, 2'b10, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check_a("t6_b1", 2'b10, 2'b11, 2'd1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    bus_a.LSUReq = 1'b0;
    tick();
    check_a("t6_rst", 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
    check_eq("t6_state", 32'(dbg_a), 32'(ARB_IDLE));
    reset = 1'b0;
    tick();
    check_a("t6_post1", 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check_a("t6_post2", 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
